// File: rtl/clock_display_scan.sv
// clock_display_scan
//   Display stage for the 12-hour clock core. It scans a 4-digit multiplexed
//   7-segment display (HH:MM) with a colon, a PM dot, leading-zero blanking
//   and a short all-off interval at the start of every digit slot. The time
//   is snapshotted once per scan frame, so a frame never shows a torn update.
//
//   Optional feature macro: SECONDS_VIEW_EN adds input show_sec. When it is
//   latched high at a snapshot, the display shows MM:SS instead of HH:MM.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   ena          advance enable; low freezes all state and outputs
//   hours        clock core hours (valid 1-12)
//   minutes      clock core minutes (valid 0-59)
//   seconds      clock core seconds (valid 0-59)
//   am_pm        1 = PM
//   show_sec     (SECONDS_VIEW_EN only) select MM:SS view at snapshot
//   seg          segments {g,f,e,d,c,b,a}
//   dp           decimal point (PM indicator on the minutes-ones digit)
//   dig_sel      one-hot digit enable, bit0 = hours tens .. bit3 = minutes ones
//   colon        colon LED, lit on even seconds
//   frame_start  one-cycle pulse after each snapshot load
//   err          snapshot holds an invalid time
module clock_display_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       am_pm,
`ifdef SECONDS_VIEW_EN
  input  logic       show_sec,
`endif
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig_sel,
  output logic       colon,
  output logic       frame_start,
  output logic       err
);

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  BLANK_C   = CW'(BLANK_CYC);
  localparam logic [6:0]     SEG_INV   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic           DP_INV    = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

  // 7-segment code for a decimal digit; anything else is blank
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  // {tens, ones} of a 0-63 value by compare/subtract (no divider)
  function automatic logic [7:0] bcd_split(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v >= 6'd60) begin
      tens = 4'd6; ones = 4'(v - 6'd60);
    end else if (v >= 6'd50) begin
      tens = 4'd5; ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4; ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3; ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2; ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1; ones = 4'(v - 6'd10);
    end else begin
      tens = 4'd0; ones = v[3:0];
    end
    return {tens, ones};
  endfunction

  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic [1:0]    idx_r, idx_nx_s;
  logic          load_s;
  logic [3:0]    snap_hours_r, hours_nx_s;
  logic [5:0]    snap_min_r, min_nx_s;
  logic [5:0]    snap_sec_r, sec_nx_s;
  logic          snap_pm_r, pm_nx_s;
  logic          view_r, view_nx_s, view_in_s;
  logic          err_r, err_nx_s;
  logic          frame_start_r;
  logic [6:0]    seg_r, digit_s;
  logic          dp_r, dp_nx_s;
  logic [3:0]    dig_sel_r, dig_nx_s;
  logic          colon_r, colon_nx_s;
  logic [7:0]    hr_bcd_s, min_bcd_s, sec_bcd_s;

`ifdef SECONDS_VIEW_EN
  assign view_in_s = show_sec;
`else
  assign view_in_s = 1'b0;
`endif

  // prescaler and digit index advance; a snapshot loads on the 3->0 wrap
  always_comb begin
    cnt_nx_s = cnt_r;
    idx_nx_s = idx_r;
    load_s   = 1'b0;
    if (ena) begin
      if (cnt_r == CNT_LAST) begin
        cnt_nx_s = '0;
        idx_nx_s = idx_r + 2'd1;
        load_s   = (idx_r == 2'd3);
      end else begin
        cnt_nx_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // next snapshot contents and validity flag
  always_comb begin
    hours_nx_s = snap_hours_r;
    min_nx_s   = snap_min_r;
    sec_nx_s   = snap_sec_r;
    pm_nx_s    = snap_pm_r;
    view_nx_s  = view_r;
    err_nx_s   = err_r;
    if (load_s) begin
      hours_nx_s = hours;
      min_nx_s   = minutes;
      sec_nx_s   = seconds;
      pm_nx_s    = am_pm;
      view_nx_s  = view_in_s;
      err_nx_s   = (hours == 4'd0) || (hours > 4'd12) ||
                   (minutes > 6'd59) || (seconds > 6'd59);
    end else begin
      err_nx_s   = err_r;
    end
  end

  assign hr_bcd_s  = bcd_split({2'b00, hours_nx_s});
  assign min_bcd_s = bcd_split(min_nx_s);
  assign sec_bcd_s = bcd_split(sec_nx_s);

  // output decode from the next state, so registered outputs line up with the scan
  always_comb begin
    digit_s    = 7'h00;
    dp_nx_s    = 1'b0;
    colon_nx_s = 1'b0;
    if (err_nx_s) begin
      digit_s = 7'h40;
    end else if (view_nx_s) begin
      colon_nx_s = 1'b1;
      case (idx_nx_s)
        2'd0:    digit_s = seg_code(min_bcd_s[7:4]);
        2'd1:    digit_s = seg_code(min_bcd_s[3:0]);
        2'd2:    digit_s = seg_code(sec_bcd_s[7:4]);
        2'd3:    digit_s = seg_code(sec_bcd_s[3:0]);
        default: digit_s = 7'h00;
      endcase
    end else begin
      colon_nx_s = ~sec_nx_s[0];
      dp_nx_s    = (idx_nx_s == 2'd3) ? pm_nx_s : 1'b0;
      case (idx_nx_s)
        2'd0:    digit_s = (hours_nx_s < 4'd10) ? 7'h00 : seg_code(hr_bcd_s[7:4]);
        2'd1:    digit_s = seg_code(hr_bcd_s[3:0]);
        2'd2:    digit_s = seg_code(min_bcd_s[7:4]);
        2'd3:    digit_s = seg_code(min_bcd_s[3:0]);
        default: digit_s = 7'h00;
      endcase
    end
    // ghost blanking: every slot starts with BLANK_CYC cycles of no digit enabled
    if (cnt_nx_s >= BLANK_C) begin
      dig_nx_s = 4'b0001 << idx_nx_s;
    end else begin
      dig_nx_s = 4'b0000;
    end
  end

  // state, snapshot and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r         <= '0;
      idx_r         <= 2'd0;
      snap_hours_r  <= 4'd12;
      snap_min_r    <= 6'd0;
      snap_sec_r    <= 6'd0;
      snap_pm_r     <= 1'b0;
      view_r        <= 1'b0;
      err_r         <= 1'b0;
      frame_start_r <= 1'b0;
      seg_r         <= SEG_INV;
      dp_r          <= DP_INV;
      dig_sel_r     <= 4'b0000;
      colon_r       <= 1'b0;
    end else begin
      frame_start_r <= load_s;
      if (ena) begin
        cnt_r        <= cnt_nx_s;
        idx_r        <= idx_nx_s;
        snap_hours_r <= hours_nx_s;
        snap_min_r   <= min_nx_s;
        snap_sec_r   <= sec_nx_s;
        snap_pm_r    <= pm_nx_s;
        view_r       <= view_nx_s;
        err_r        <= err_nx_s;
        seg_r        <= digit_s ^ SEG_INV;
        dp_r         <= dp_nx_s ^ DP_INV;
        dig_sel_r    <= dig_nx_s;
        colon_r      <= colon_nx_s;
      end
    end
  end

  assign seg         = seg_r;
  assign dp          = dp_r;
  assign dig_sel     = dig_sel_r;
  assign colon       = colon_r;
  assign frame_start = frame_start_r;
  assign err         = err_r;

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan with SCAN_DIV=4, BLANK_CYC=1.
// Scan position pos = index*4 + count; outputs are sampled on the falling edge.
module tb_clock_display_scan;

  typedef struct packed {
    logic [3:0]  hours;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic        am_pm;
    logic        show_sec;
    logic [27:0] segs;   // {d3,d2,d1,d0}
    logic        dp3;
    logic        colon;
    logic        err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, ena, am_pm;
  logic [3:0] hours;
  logic [5:0] minutes, seconds;
`ifdef SECONDS_VIEW_EN
  logic       show_sec;
`endif
  logic [6:0] seg;
  logic       dp, colon, frame_start, err;
  logic [3:0] dig_sel;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t cur;
  vec_t exp_q[$];
  vec_t vecs[9];
  vec_t v_reset, v_906;

  always #5 clk = ~clk;

  clock_display_scan #(.SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .hours(hours), .minutes(minutes), .seconds(seconds), .am_pm(am_pm),
`ifdef SECONDS_VIEW_EN
    .show_sec(show_sec),
`endif
    .seg(seg), .dp(dp), .dig_sel(dig_sel), .colon(colon),
    .frame_start(frame_start), .err(err)
  );

  function automatic vec_t mk(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s,
                              input logic pm, input logic ss,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic dp3, input logic col, input logic er);
    vec_t v;
    v.hours = h; v.minutes = m; v.seconds = s; v.am_pm = pm; v.show_sec = ss;
    v.segs = {s3, s2, s1, s0};
    v.dp3 = dp3; v.colon = col; v.err = er;
    return v;
  endfunction

  // apply a vector's inputs; it becomes visible after the next wrap
  task automatic drive(input vec_t v);
    hours = v.hours; minutes = v.minutes; seconds = v.seconds; am_pm = v.am_pm;
`ifdef SECONDS_VIEW_EN
    show_sec = v.show_sec;
`endif
    exp_q.push_back(v);
  endtask

  task automatic check_pos(input string tag, input int i);
    logic [14:0] e, a;
    int slot;
    slot = i / 4;
    e = {(i == 0), cur.err, cur.colon, (slot == 3) ? cur.dp3 : 1'b0,
         (i % 4 >= 1) ? (4'b0001 << slot) : 4'b0000, cur.segs[slot*7 +: 7]};
    a = {frame_start, err, colon, dp, dig_sel, seg};
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s pos=%0d {fs,err,colon,dp,dig_sel,seg} got=%h expected=%h", tag, i, a, e);
    end
  endtask

  task automatic check_range(input string tag, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      check_pos(tag, i);
      @(negedge clk);
    end
  endtask

  task automatic check_reset(input string tag);
    logic [14:0] a;
    a = {frame_start, err, colon, dp, dig_sel, seg};
    n_checks++;
    if (a !== 15'h0000) begin
      n_errors++;
      $display("FAIL %s got=%h expected=0000", tag, a);
    end
  endtask

  task automatic next_expected();
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty got=0 expected=1");
    end else begin
      cur = exp_q.pop_front();
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    v_reset = mk(4'd12, 6'd0, 6'd0, 1'b0, 1'b0, 7'h06, 7'h5B, 7'h3F, 7'h3F, 1'b0, 1'b1, 1'b0);
    v_906   = mk(4'd9, 6'd6, 6'd7, 1'b1, 1'b0, 7'h00, 7'h6F, 7'h3F, 7'h7D, 1'b1, 1'b0, 1'b0);
    vecs[0] = mk(4'd9,  6'd5,  6'd7,  1'b1, 1'b0, 7'h00, 7'h6F, 7'h3F, 7'h6D, 1'b1, 1'b0, 1'b0);
    vecs[1] = mk(4'd13, 6'd0,  6'd0,  1'b0, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 1'b0, 1'b1);
    vecs[2] = mk(4'd11, 6'd59, 6'd58, 1'b0, 1'b0, 7'h06, 7'h06, 7'h6D, 7'h6F, 1'b0, 1'b1, 1'b0);
    vecs[3] = mk(4'd0,  6'd10, 6'd10, 1'b1, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 1'b0, 1'b1);
    vecs[4] = mk(4'd12, 6'd60, 6'd0,  1'b1, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 1'b0, 1'b1);
    vecs[5] = mk(4'd1,  6'd0,  6'd60, 1'b0, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 1'b0, 1'b1);
    vecs[6] = mk(4'd10, 6'd30, 6'd59, 1'b1, 1'b0, 7'h06, 7'h3F, 7'h4F, 7'h3F, 1'b1, 1'b0, 1'b0);
`ifdef SECONDS_VIEW_EN
    vecs[7] = mk(4'd9,  6'd5,  6'd37, 1'b1, 1'b1, 7'h3F, 7'h6D, 7'h4F, 7'h07, 1'b0, 1'b1, 1'b0);
`else
    vecs[7] = mk(4'd9,  6'd5,  6'd37, 1'b1, 1'b0, 7'h00, 7'h6F, 7'h3F, 7'h6D, 1'b1, 1'b0, 1'b0);
`endif
    vecs[8] = vecs[0];

    // reset held three cycles
    drive(vecs[0]);
    repeat (3) begin
      @(negedge clk);
      check_reset("reset_hold");
    end
    rst = 1'b0;
    cur = v_reset;
    @(negedge clk);
    check_range("reset_frame", 1, 15);

    // table: each frame shows the vector driven one frame earlier
    for (int k = 0; k < 9; k++) begin
      next_expected();
      if (k + 1 < 9) begin
        drive(vecs[k + 1]);
      end
      check_range("table", 0, 15);
    end

    // mid-frame input change stays invisible until the next snapshot
    check_range("midframe", 0, 4);
    minutes = 6'd6;
    check_range("midframe", 5, 15);
    cur = v_906;
    check_range("midframe_next", 0, 15);

    // freeze at count 2, then freeze exactly on the wrap position
    check_range("freeze", 0, 1);
    ena = 1'b0;
    repeat (10) begin
      check_pos("freeze_hold", 2);
      @(negedge clk);
    end
    ena = 1'b1;
    check_range("freeze_resume", 2, 14);
    ena = 1'b0;
    repeat (3) begin
      check_pos("wrap_hold", 15);
      @(negedge clk);
    end
    ena = 1'b1;
    check_range("wrap_resume", 15, 15);
    check_range("after_wrap", 0, 5);

    // reset in the middle of a slot
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    cur = v_reset;
    @(negedge clk);
    check_range("rst_frame", 1, 15);
    cur = v_906;
    check_range("rst_next", 0, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
